// File: rtl/axi_regs_master_if.sv
// Command/response port and AXI3 master channels of axi_regs_master.
// The master modport is the register master's view; slave is the far side.
interface axi_regs_master_if #(
  parameter int unsigned ADDRESS_BITS = 16
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDRESS_BITS-1:0] cmd_addr;
  logic [31:0]             cmd_wdata;
  logic [3:0]              cmd_wstb;
  logic                    rsp_valid;
  logic [31:0]             rsp_rdata;
  logic [1:0]              rsp_resp;
  logic                    rsp_err;
  logic [31:0]             ARADDR, AWADDR;
  logic                    ARVALID, AWVALID, WVALID;
  logic                    ARREADY, AWREADY, WREADY;
  logic [11:0]             ARID, AWID, WID;
  logic [3:0]              ARLEN, AWLEN;
  logic [1:0]              ARSIZE, AWSIZE, ARBURST, AWBURST;
  logic [31:0]             WDATA;
  logic [3:0]              WSTRB;
  logic                    WLAST;
  logic [31:0]             RDATA;
  logic [11:0]             RID;
  logic                    RLAST;
  logic [1:0]              RRESP;
  logic                    RVALID, RREADY;
  logic                    BVALID;
  logic [11:0]             BID;
  logic [1:0]              BRESP;
  logic                    BREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstb,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_err,
    output ARADDR, AWADDR, ARVALID, AWVALID, WVALID,
    input  ARREADY, AWREADY, WREADY,
    output ARID, AWID, WID, ARLEN, AWLEN, ARSIZE, AWSIZE, ARBURST, AWBURST,
    output WDATA, WSTRB, WLAST,
    input  RDATA, RID, RLAST, RRESP, RVALID,
    output RREADY,
    input  BVALID, BID, BRESP,
    output BREADY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstb,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_err,
    input  ARADDR, AWADDR, ARVALID, AWVALID, WVALID,
    output ARREADY, AWREADY, WREADY,
    input  ARID, AWID, WID, ARLEN, AWLEN, ARSIZE, AWSIZE, ARBURST, AWBURST,
    input  WDATA, WSTRB, WLAST,
    output RDATA, RID, RLAST, RRESP, RVALID,
    input  RREADY,
    output BVALID, BID, BRESP,
    input  BREADY
  );
endinterface

// File: rtl/axi_regs_master.sv
// Single-outstanding AXI3 register master: each accepted command becomes one
// single-beat AW+W+B or AR+R exchange followed by a one-cycle response pulse.
module axi_regs_master #(
  parameter int unsigned ADDRESS_BITS = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter logic [11:0] AXI_ID       = 12'h000
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  axi_regs_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic        bready_q, bready_d;
  logic        rready_q, rready_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic        rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        // cmd_ready_q is still low in the first cycle after reset release
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = BASE_ADDR | {{(30-ADDRESS_BITS){1'b0}}, bus.cmd_addr, 2'b00};
          wdata_d     = bus.cmd_wdata;
          wstrb_d     = bus.cmd_wstb;
          if (bus.cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && bus.AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && bus.WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (bus.BVALID) begin
          state_d     = IDLE;
          bready_d    = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_resp_d  = bus.BRESP;
          rsp_err_d   = (bus.BID != AXI_ID);
        end
      end
      RD_REQ: begin
        if (bus.ARREADY) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (bus.RVALID) begin
          state_d     = IDLE;
          rready_d    = 1'b0;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus.RDATA;
          rsp_resp_d  = bus.RRESP;
          rsp_err_d   = (bus.RID != AXI_ID) | ~bus.RLAST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_resp_q  <= 2'b00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.ARADDR    = addr_q;
  assign bus.AWADDR    = addr_q;
  assign bus.ARVALID   = arvalid_q;
  assign bus.AWVALID   = awvalid_q;
  assign bus.WVALID    = wvalid_q;
  assign bus.ARID      = AXI_ID;
  assign bus.AWID      = AXI_ID;
  assign bus.WID       = AXI_ID;
  assign bus.ARLEN     = 4'd0;
  assign bus.AWLEN     = 4'd0;
  assign bus.ARSIZE    = 2'b10;
  assign bus.AWSIZE    = 2'b10;
  assign bus.ARBURST   = 2'b01;
  assign bus.AWBURST   = 2'b01;
  assign bus.WDATA     = wdata_q;
  assign bus.WSTRB     = wstrb_q;
  assign bus.WLAST     = wvalid_q;
  assign bus.RREADY    = rready_q;
  assign bus.BREADY    = bready_q;
endmodule

// File: tb/tb_axi_regs_master.sv
// Directed bench for axi_regs_master: table of single commands against a
// delay-configurable AXI slave with a word memory, plus multi-cycle sequences.
module tb_axi_regs_master;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axi_regs_master_if #(.ADDRESS_BITS(16)) bus ();

  axi_regs_master #(
    .ADDRESS_BITS(16),
    .BASE_ADDR(32'h8000_0000),
    .AXI_ID(12'h000)
  ) dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave configuration, set by the stimulus process between commands
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0, cfg_b_dly = 0;
  logic [11:0] cfg_rid = 12'h0, cfg_bid = 12'h0;
  logic        cfg_rlast = 1'b1;
  logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;

  logic [31:0] mem [0:255];
  logic [31:0] aw_addr_seen, ar_addr_seen, rd_word;
  logic        wlast_seen;
  int          n_b = 0, n_r = 0;

  // Slave: sample handshakes on the edge, drive new inputs 1ns later
  initial begin
    bit aw_done, w_done, r_pend;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic [7:0] idx;
    aw_done = 0; w_done = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
    bus.BVALID = 0; bus.BID = 0; bus.BRESP = 0;
    bus.RVALID = 0; bus.RDATA = 0; bus.RID = 0; bus.RLAST = 0; bus.RRESP = 0;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (bus.AWVALID && bus.AWREADY) begin aw_done = 1; aw_addr_seen = bus.AWADDR; end
        if (bus.WVALID && bus.WREADY) begin
          w_done = 1;
          wlast_seen = bus.WLAST;
          idx = bus.AWADDR[9:2];
          for (int b = 0; b < 4; b++)
            if (bus.WSTRB[b]) mem[idx][8*b +: 8] = bus.WDATA[8*b +: 8];
        end
        if (bus.ARVALID && bus.ARREADY) begin
          r_pend = 1;
          ar_addr_seen = bus.ARADDR;
          idx = bus.ARADDR[9:2];
          rd_word = mem[idx];
        end
        if (bus.BVALID && bus.BREADY) begin aw_done = 0; w_done = 0; b_cnt = 0; n_b++; end
        if (bus.RVALID && bus.RREADY) begin r_pend = 0; r_cnt = 0; n_r++; end
      end
      #1;
      if (!rst_n) begin
        aw_done = 0; w_done = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0; bus.BVALID = 0; bus.RVALID = 0;
      end else begin
        bus.AWREADY = bus.AWVALID && (aw_cnt == cfg_aw_dly);
        aw_cnt = bus.AWVALID ? aw_cnt + 1 : 0;
        bus.WREADY = bus.WVALID && (w_cnt == cfg_w_dly);
        w_cnt = bus.WVALID ? w_cnt + 1 : 0;
        bus.ARREADY = bus.ARVALID && (ar_cnt == cfg_ar_dly);
        ar_cnt = bus.ARVALID ? ar_cnt + 1 : 0;
        bus.BVALID = aw_done && w_done && (b_cnt >= cfg_b_dly);
        if (aw_done && w_done) b_cnt++;
        bus.BID = cfg_bid; bus.BRESP = cfg_bresp;
        bus.RVALID = r_pend && (r_cnt >= cfg_r_dly);
        if (r_pend) r_cnt++;
        bus.RDATA = rd_word; bus.RID = cfg_rid; bus.RLAST = cfg_rlast; bus.RRESP = cfg_rresp;
      end
    end
  end

  // Call 1ns after an edge; returns 1ns after the accepting edge (cycle N+1)
  task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    bit ok;
    ok = 0;
    bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d; bus.cmd_wstb = s;
    bus.cmd_valid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      if (bus.cmd_ready) ok = 1;
    end
    #1;
    bus.cmd_valid = 0;
    check("cmd_accept", 64'(ok), 64'd1);
  endtask

  // Returns in the rsp_valid cycle; lat counts N+lat from the accept edge
  task automatic wait_rsp(output int lat, output int ar_cyc);
    lat = 1;
    ar_cyc = 0;
    while (!bus.rsp_valid && lat < 40) begin
      if (bus.ARVALID) ar_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_arrived", 64'(bus.rsp_valid), 64'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    int          aw_dly, w_dly, ar_dly, r_dly, b_dly;
    logic [11:0] rid;
    logic        rlast;
    logic [1:0]  rresp;
    logic [11:0] bid;
    logic [1:0]  bresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [15:0] a, logic [31:0] d, logic [3:0] s,
                              int aw, int w, int ar, int r, int b,
                              logic [11:0] rid, logic rlast, logic [1:0] rresp,
                              logic [11:0] bid, logic [1:0] bresp,
                              logic [31:0] erd, logic [1:0] ersp, logic eerr, int elat);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.wstb = s;
    v.aw_dly = aw; v.w_dly = w; v.ar_dly = ar; v.r_dly = r; v.b_dly = b;
    v.rid = rid; v.rlast = rlast; v.rresp = rresp; v.bid = bid; v.bresp = bresp;
    v.exp_rdata = erd; v.exp_resp = ersp; v.exp_err = eerr; v.exp_lat = elat;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    int lat, ar_cyc, aw_c, w_c, viol, rn, br_first, acc, rsp_n;
    logic [31:0] rsp_log [8];
    logic [31:0] exp_addr;
    int b0, r0;

    vecs[0]  = mk(1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 0,0,0,0,0, 12'h000,1,2'b00, 12'h000,2'b00, 32'h0,        2'b00,0, 3);
    vecs[1]  = mk(0, 16'h0010, 32'h0,         4'h0, 0,0,0,0,0, 12'h000,1,2'b00, 12'h000,2'b00, 32'hDEAD_BEEF,2'b00,0, 3);
    vecs[2]  = mk(1, 16'h0011, 32'hA5A5_A5A5, 4'h5, 0,0,0,0,2, 12'h000,1,2'b00, 12'h000,2'b01, 32'h0,        2'b01,0, 5);
    vecs[3]  = mk(0, 16'h0011, 32'h0,         4'h0, 0,0,0,0,0, 12'h000,1,2'b00, 12'h000,2'b00, 32'h00A5_00A5,2'b00,0, 3);
    vecs[4]  = mk(1, 16'h0010, 32'h1234_5678, 4'hF, 0,0,0,0,0, 12'h000,1,2'b00, 12'h000,2'b00, 32'h0,        2'b00,0, 3);
    vecs[5]  = mk(0, 16'h0010, 32'h0,         4'h0, 0,0,5,3,0, 12'h000,1,2'b00, 12'h000,2'b00, 32'h1234_5678,2'b00,0, 11);
    vecs[6]  = mk(0, 16'h0010, 32'h0,         4'h0, 0,0,0,0,0, 12'h001,0,2'b10, 12'h000,2'b00, 32'h1234_5678,2'b10,1, 3);
    vecs[7]  = mk(1, 16'h0020, 32'h0BAD_F00D, 4'hF, 0,0,0,0,0, 12'h000,1,2'b00, 12'h005,2'b11, 32'h0,        2'b11,1, 3);
    vecs[8]  = mk(0, 16'h0020, 32'h0,         4'h0, 0,0,0,0,0, 12'h000,1,2'b01, 12'h000,2'b00, 32'h0BAD_F00D,2'b01,0, 3);
    vecs[9]  = mk(1, 16'h0021, 32'h1122_3344, 4'hC, 1,3,0,0,1, 12'h000,1,2'b00, 12'h000,2'b00, 32'h0,        2'b00,0, 7);
    vecs[10] = mk(0, 16'h0021, 32'h0,         4'h0, 0,0,2,0,0, 12'h000,1,2'b00, 12'h000,2'b00, 32'h1122_0000,2'b00,0, 5);

    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_wstb = 0;

    // Power-on reset
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_handshake", 64'({bus.cmd_ready, bus.rsp_valid, bus.ARVALID, bus.AWVALID,
                                bus.WVALID, bus.RREADY, bus.BREADY, bus.WLAST}), 64'h0);
    check("rst_rsp", 64'({bus.rsp_rdata, bus.rsp_resp, bus.rsp_err}), 64'h0);
    check("rst_addr", {bus.AWADDR, bus.ARADDR}, 64'h0);
    #1 rst_n = 1'b1;
    #1 check("cmd_ready_pre_edge", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk); #1;
    check("cmd_ready_post_edge", 64'(bus.cmd_ready), 64'd1);
    check("axi_constants", 64'({bus.ARLEN, bus.AWLEN, bus.ARSIZE, bus.AWSIZE, bus.ARBURST,
                                bus.AWBURST, bus.ARID, bus.AWID, bus.WID}),
          64'({4'd0, 4'd0, 2'b10, 2'b10, 2'b01, 2'b01, 12'h0, 12'h0, 12'h0}));

    for (int i = 0; i < NV; i++) begin
      cfg_aw_dly = vecs[i].aw_dly; cfg_w_dly = vecs[i].w_dly; cfg_ar_dly = vecs[i].ar_dly;
      cfg_r_dly = vecs[i].r_dly; cfg_b_dly = vecs[i].b_dly;
      cfg_rid = vecs[i].rid; cfg_rlast = vecs[i].rlast; cfg_rresp = vecs[i].rresp;
      cfg_bid = vecs[i].bid; cfg_bresp = vecs[i].bresp;
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstb);
      wait_rsp(lat, ar_cyc);
      $display("[TB] vec %0d %s addr=%h lat=%0d rdata=%h resp=%0d err=%0d", i,
               vecs[i].wr ? "WR" : "RD", vecs[i].addr, lat, bus.rsp_rdata, bus.rsp_resp, bus.rsp_err);
      exp_addr = 32'h8000_0000 | {14'h0, vecs[i].addr, 2'b00};
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_rdata", i), 64'(bus.rsp_rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("v%0d_resp", i), 64'(bus.rsp_resp), 64'(vecs[i].exp_resp));
      check($sformatf("v%0d_err", i), 64'(bus.rsp_err), 64'(vecs[i].exp_err));
      if (vecs[i].wr) begin
        check($sformatf("v%0d_awaddr", i), 64'(aw_addr_seen), 64'(exp_addr));
        check($sformatf("v%0d_wlast", i), 64'(wlast_seen), 64'd1);
      end else begin
        check($sformatf("v%0d_araddr", i), 64'(ar_addr_seen), 64'(exp_addr));
        check($sformatf("v%0d_arvalid_cycles", i), 64'(ar_cyc), 64'(vecs[i].ar_dly + 1));
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_single_pulse", i), 64'(bus.rsp_valid), 64'd0);
      check($sformatf("v%0d_rdata_hold", i), 64'(bus.rsp_rdata), 64'(vecs[i].exp_rdata));
    end

    // Write with AW/W handshakes in both orders
    for (int k = 0; k < 2; k++) begin
      cfg_aw_dly = (k == 0) ? 4 : 0; cfg_w_dly = (k == 0) ? 0 : 4; cfg_b_dly = 0;
      cfg_bid = 12'h0; cfg_bresp = 2'b00;
      issue(1'b1, 16'h0050, 32'h55AA_55AA, 4'hF);
      aw_c = 0; w_c = 0; viol = 0; rn = 0; br_first = 0;
      for (int c = 1; c <= 15; c++) begin
        if (bus.AWVALID) aw_c++;
        if (bus.WVALID) w_c++;
        if (bus.BREADY && (bus.AWVALID || bus.WVALID)) viol++;
        if (bus.BREADY && br_first == 0) br_first = c;
        if (bus.rsp_valid) rn++;
        @(posedge clk); #1;
      end
      $display("[TB] order %0d aw_cycles=%0d w_cycles=%0d bready_at=%0d rsp=%0d", k, aw_c, w_c, br_first, rn);
      check($sformatf("ord%0d_aw_cycles", k), 64'(aw_c), (k == 0) ? 64'd5 : 64'd1);
      check($sformatf("ord%0d_w_cycles", k), 64'(w_c), (k == 0) ? 64'd1 : 64'd5);
      check($sformatf("ord%0d_bready_early", k), 64'(viol), 64'd0);
      check($sformatf("ord%0d_bready_first", k), 64'(br_first), 64'd6);
      check($sformatf("ord%0d_rsp_count", k), 64'(rn), 64'd1);
    end
    cfg_aw_dly = 0; cfg_w_dly = 0;

    // Eight back-to-back commands with cmd_valid held high
    b0 = n_b; r0 = n_r; acc = 0; rsp_n = 0;
    bus.cmd_valid = 1;
    for (int c = 0; c < 200 && (acc < 8 || rsp_n < 8); c++) begin
      bus.cmd_write = (acc % 2 == 0);
      bus.cmd_addr  = 16'h0040 + 16'(acc / 2);
      bus.cmd_wdata = 32'hC0DE_0000 | 32'(acc / 2);
      bus.cmd_wstb  = 4'hF;
      bus.cmd_valid = (acc < 8);
      @(posedge clk);
      if (bus.cmd_valid && bus.cmd_ready) acc++;
      #1;
      if (bus.rsp_valid && rsp_n < 8) begin
        rsp_log[rsp_n] = bus.rsp_rdata;
        $display("[TB] b2b rsp %0d rdata=%h", rsp_n, bus.rsp_rdata);
        rsp_n++;
      end
    end
    bus.cmd_valid = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) rsp_n++;
    end
    check("b2b_accepted", 64'(acc), 64'd8);
    check("b2b_responses", 64'(rsp_n), 64'd8);
    check("b2b_b_handshakes", 64'(n_b - b0), 64'd4);
    check("b2b_r_handshakes", 64'(n_r - r0), 64'd4);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("b2b_wr%0d_rdata", p), 64'(rsp_log[2*p]), 64'h0);
      check($sformatf("b2b_rd%0d_rdata", p), 64'(rsp_log[2*p+1]), 64'(32'hC0DE_0000 | 32'(p)));
    end

    // Reset during WR_REQ, then a clean read
    cfg_aw_dly = 10; cfg_w_dly = 10;
    issue(1'b1, 16'h0010, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk); #1;
    check("mid_awvalid_before_rst", 64'(bus.AWVALID), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_handshake", 64'({bus.cmd_ready, bus.rsp_valid, bus.ARVALID, bus.AWVALID,
                                    bus.WVALID, bus.RREADY, bus.BREADY, bus.WLAST}), 64'h0);
    check("mid_rst_rsp", 64'({bus.rsp_rdata, bus.rsp_resp, bus.rsp_err}), 64'h0);
    check("mid_rst_data", 64'({bus.AWADDR, bus.WDATA}), 64'h0);
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
    cfg_rid = 12'h0; cfg_rlast = 1'b1; cfg_rresp = 2'b00;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("mid_cmd_ready_pre_edge", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk); #1;
    check("mid_cmd_ready_post_edge", 64'(bus.cmd_ready), 64'd1);
    issue(1'b0, 16'h0010, 32'h0, 4'h0);
    wait_rsp(lat, ar_cyc);
    $display("[TB] post-reset read lat=%0d rdata=%h err=%0d", lat, bus.rsp_rdata, bus.rsp_err);
    check("post_rst_latency", 64'(lat), 64'd3);
    check("post_rst_rdata", 64'(bus.rsp_rdata), 64'h1234_5678);
    check("post_rst_err", 64'(bus.rsp_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_regs_master.md
# axi_regs_master

Single-outstanding AXI3 (GP-port style) master that turns simple register read/write commands into single-beat AXI transactions. It is the initiator counterpart of the SATA controller's AXI register slave: it drives register accesses across an AXI link, for self-test loopback and for the internal sequencers. Each command produces exactly one AW+W+B or AR+R exchange and one response pulse.

## Interface
- ADDRESS_BITS, 16: width of the command word address.
- BASE_ADDR, 32'h8000_0000: OR-ed into every AxADDR; bits [ADDRESS_BITS+1:0] must be 0.
- AXI_ID, 12'h000: ID driven on ARID/AWID/WID and expected on RID/BID.
- ACLK  input  1  clock; the only clock.
- ARESETN  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block idle; command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDRESS_BITS  32-bit word address.
- cmd_wdata  input  32  write data.
- cmd_wstb  input  4  write byte strobes.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  read data; 0 for writes.
- rsp_resp  output  2  captured RRESP/BRESP.
- rsp_err  output  1  ID mismatch or missing RLAST.
- ARADDR, AWADDR  output  32  BASE_ADDR | {cmd_addr, 2'b00}.
- ARVALID, AWVALID, WVALID  output  1  channel valids.
- ARREADY, AWREADY, WREADY  input  1  channel readies.
- ARID, AWID, WID  output  12  constant AXI_ID.
- ARLEN, AWLEN  output  4  constant 0.
- ARSIZE, AWSIZE  output  2  constant 2'b10.
- ARBURST, AWBURST  output  2  constant 2'b01.
- WDATA  output  32; WSTRB  output  4; WLAST  output  1 (equals WVALID).
- RDATA  input  32; RID  input  12; RLAST  input  1; RRESP  input  2; RVALID  input  1; RREADY  output  1.
- BVALID  input  1; BID  input  12; BRESP  input  2; BREADY  output  1.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE: cmd_ready=1. On accept, register addr/data/strobes; go to WR_REQ (write) or RD_REQ (read).
- WR_REQ: AWVALID and WVALID raised together; each drops independently after its own handshake (AWREADY before, after, or simultaneous with WREADY all legal). When both are done, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID: capture BRESP; rsp_err = (BID != AXI_ID). Return to IDLE.
- RD_REQ: ARVALID=1 until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID: capture RDATA and RRESP; rsp_err = (RID != AXI_ID) | ~RLAST. Return to IDLE.
- Valids never drop before their handshake. Address/data stay stable while valid.
- RRESP/BRESP values are passed through unmodified; the block never retries.
- cmd inputs are ignored outside IDLE.

## Timing
- Reset (async assert): all outputs 0, including cmd_ready, rsp_* and all VALID/READY; FSM to IDLE. cmd_ready rises on the first ACLK edge after release.
- All outputs are registered.
- Command accepted at edge N: AxVALID (and WVALID) high from N+1.
- Handshake at edge M completes the request phase: that VALID is low from M+1. BREADY/RREADY are high from the edge after the last request handshake.
- B/R handshake at edge K: rsp_valid high for exactly cycle K+1, with rsp_* valid in that cycle. cmd_ready=1 in the same cycle, so a back-to-back command can be accepted at K+1.
- Minimum latency with slave readies tied high: accept N, response pulse N+3, for both reads and writes.
- rsp_rdata/rsp_resp/rsp_err hold until the next response. rsp_rdata is cleared to 0 on write responses.
- Reset mid-transaction abandons the transaction silently; the interconnect and slave are reset together.

## Test plan
- Write 0xDEADBEEF, strobe 0xF, to word 0x0010, all readies high -> AWADDR=0x8000_0040, WLAST=1, AWLEN=0; rsp_valid at N+3; rsp_resp=0, rsp_err=0.
- Read word 0x0010 with the slave returning RDATA 0x12345678 after 5 wait cycles on ARREADY and 3 on RVALID -> ARVALID held for 6 cycles; rsp_rdata=0x12345678 one cycle after the R handshake.
- Write with WREADY arriving 4 cycles before AWREADY, then repeated with the order reversed -> each VALID drops individually; BREADY only after both handshakes; exactly one rsp_valid per command.
- Read returning RID=0x001, RLAST=0, RRESP=2'b10 -> rsp_err=1, rsp_resp=2'b10.
- 8 back-to-back alternating writes/reads with cmd_valid held high -> 8 responses, one per command; no command lost or duplicated; the read returns the last written value from the BRAM model.
- Assert ARESETN low while in WR_REQ with AWVALID high -> all outputs 0 immediately (asynchronous); after release, cmd_ready=1 one edge later and a new read completes normally.
